// File: rtl/digdug_hv_pkg.sv
// -----------------------------------------------------------------------------
// digdug_hv_pkg
// Shared timing constants and types for the Dig Dug video timing generator.
//   H_TOTAL/V_TOTAL     : pixels per line / lines per frame
//   H_ACTIVE            : visible pixels per line
//   V_START/V_END       : first visible line / first line after visible area
//   HS_START/HS_LEN     : horizontal sync window start and width (pixels)
//   VS_LEN              : vertical sync width (lines)
//   CE_DIV_DEFAULT      : MCLK cycles per pixel
//   hv_cnt_t            : 9-bit pixel/line counter type
//   rgb_t               : 24-bit expanded colour
// -----------------------------------------------------------------------------
package digdug_hv_pkg;

    localparam int H_TOTAL        = 384;
    localparam int V_TOTAL        = 264;
    localparam int H_ACTIVE       = 288;
    localparam int V_START        = 16;
    localparam int V_END          = 240;
    localparam int HS_START       = 304;
    localparam int HS_LEN         = 32;
    localparam int VS_LEN         = 3;
    localparam int CE_DIV_DEFAULT = 8;

    typedef logic [8:0] hv_cnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/digdug_rgb_expand.sv
// -----------------------------------------------------------------------------
// digdug_rgb_expand
// Combinational expansion of the core's 8-bit palette byte to 24-bit RGB by
// bit replication, so full scale maps to 8'hFF and zero stays zero.
//   pout_i [7:0] : palette byte, [2:0]=R, [5:3]=G, [7:6]=B
//   rgb_o        : expanded colour
// -----------------------------------------------------------------------------
module digdug_rgb_expand
    import digdug_hv_pkg::*;
(
    input  logic [7:0] pout_i,
    output rgb_t       rgb_o
);

    assign rgb_o.r = {pout_i[2:0], pout_i[2:0], pout_i[2:1]};
    assign rgb_o.g = {pout_i[5:3], pout_i[5:3], pout_i[5:4]};
    assign rgb_o.b = {4{pout_i[7:6]}};

endmodule

// File: rtl/digdug_hvgen.sv
// -----------------------------------------------------------------------------
// digdug_hvgen
// Video timing generator and pixel output stage for the Dig Dug core.
// Divides MCLK down to a one-cycle pixel enable, runs the PH/PV counters,
// decodes registered blank/sync flags aligned with PH/PV, and pipes the
// palette byte through two pixel-tick stages to 24-bit RGB.
//
// Ports:
//   MCLK        in   master clock
//   RESET       in   synchronous active-high reset
//   POUT[7:0]   in   palette byte from the core
//   HOFS/VOFS   in   sync offsets, two's complement (only with
//                    DIGDUG_HVGEN_ADJUST_EN defined)
//   CE_PIX      out  one-MCLK-wide pixel enable
//   PH/PV[8:0]  out  pixel / line counters
//   HBLK/VBLK   out  blanking flags
//   HSYNC/VSYNC out  active-high syncs
//   R/G/B[7:0]  out  expanded colour, zero while blanked
//
// Build option: define DIGDUG_HVGEN_ADJUST_EN to add HOFS/VOFS sync shifting.
// -----------------------------------------------------------------------------
module digdug_hvgen #(
    parameter int CE_DIV   = digdug_hv_pkg::CE_DIV_DEFAULT,
    parameter int H_TOTAL  = digdug_hv_pkg::H_TOTAL,
    parameter int V_TOTAL  = digdug_hv_pkg::V_TOTAL,
    parameter int H_ACTIVE = digdug_hv_pkg::H_ACTIVE,
    parameter int V_START  = digdug_hv_pkg::V_START,
    parameter int V_END    = digdug_hv_pkg::V_END,
    parameter int HS_START = digdug_hv_pkg::HS_START,
    parameter int HS_LEN   = digdug_hv_pkg::HS_LEN,
    parameter int VS_LEN   = digdug_hv_pkg::VS_LEN
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic [7:0] POUT,
`ifdef DIGDUG_HVGEN_ADJUST_EN
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
`endif
    output logic       CE_PIX,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);

    logic [3:0]                 div_q;
    digdug_hv_pkg::hv_cnt_t     ph_q, pv_q, ph_d, pv_d;
    logic                       hblk_q, vblk_q, hs_q, vs_q;
    logic                       hs_d, vs_d;
    logic [7:0]                 pix_s1_q;
    logic                       blank_s1_q;
    digdug_hv_pkg::rgb_t        rgb_q, rgb_x;
    logic                       ce;
    logic [3:0]                 hofs_d, vofs_d;

    assign ce = (div_q == 4'(CE_DIV - 1));

`ifdef DIGDUG_HVGEN_ADJUST_EN
    logic [3:0] hofs_q, vofs_q;
    // Offsets only change on the first tick of a frame so a frame never
    // sees two different sync positions.
    assign hofs_d = (ce && ph_q == '0 && pv_q == '0) ? HOFS : hofs_q;
    assign vofs_d = (ce && ph_q == '0 && pv_q == '0) ? VOFS : vofs_q;
`else
    assign hofs_d = 4'd0;
    assign vofs_d = 4'd0;
`endif

    // Next counter values; only committed on a pixel tick.
    always_comb begin
        ph_d = ph_q + 9'd1;
        pv_d = pv_q;
        if (ph_q >= 9'(H_TOTAL - 1)) begin
            ph_d = '0;
            pv_d = (pv_q >= 9'(V_TOTAL - 1)) ? 9'd0 : pv_q + 9'd1;
        end
    end

    // Sync windows, decoded from the next counter values so the registered
    // flags line up with PH/PV.
    logic [8:0] hs_lo, hs_hi;
    logic [9:0] vt10, lo_raw, hi_raw, vs_lo, vs_hi, pv10;
    always_comb begin
        hs_lo  = 9'(HS_START) + {{5{hofs_d[3]}}, hofs_d};
        hs_hi  = hs_lo + 9'(HS_LEN);
        hs_d   = (ph_d >= hs_lo) && (ph_d < hs_hi);

        vt10   = 10'(V_TOTAL);
        pv10   = {1'b0, pv_d};
        lo_raw = {{6{vofs_d[3]}}, vofs_d};
        hi_raw = lo_raw + 10'(VS_LEN);
        // Negative offsets fold back into the end of the previous frame.
        vs_lo  = vofs_d[3] ? lo_raw + vt10 : lo_raw;
        vs_hi  = hi_raw[9] ? hi_raw + vt10 : hi_raw;
        if (vs_hi >= vt10) begin
            vs_hi = vs_hi - vt10;
        end
        // A window whose end wrapped past zero covers [lo, V_TOTAL) and [0, hi).
        if (vs_lo < vs_hi) begin
            vs_d = (pv10 >= vs_lo) && (pv10 < vs_hi);
        end else begin
            vs_d = (pv10 >= vs_lo) || (pv10 < vs_hi);
        end
    end

    digdug_rgb_expand u_expand (
        .pout_i (pix_s1_q),
        .rgb_o  (rgb_x)
    );

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            div_q      <= '0;
            ph_q       <= '0;
            pv_q       <= '0;
            hblk_q     <= 1'b0;
            vblk_q     <= 1'b1;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            pix_s1_q   <= '0;
            blank_s1_q <= 1'b1;
            rgb_q      <= '0;
`ifdef DIGDUG_HVGEN_ADJUST_EN
            hofs_q     <= '0;
            vofs_q     <= '0;
`endif
        end else begin
            div_q <= ce ? 4'd0 : div_q + 4'd1;
`ifdef DIGDUG_HVGEN_ADJUST_EN
            hofs_q <= hofs_d;
            vofs_q <= vofs_d;
`endif
            if (ce) begin
                ph_q       <= ph_d;
                pv_q       <= pv_d;
                hblk_q     <= (ph_d >= 9'(H_ACTIVE));
                vblk_q     <= (pv_d < 9'(V_START)) || (pv_d >= 9'(V_END));
                hs_q       <= hs_d;
                vs_q       <= vs_d;
                // Stage 1 captures the byte with the blank state of the
                // pixel currently on PH/PV.
                pix_s1_q   <= POUT;
                blank_s1_q <= hblk_q | vblk_q;
                rgb_q      <= blank_s1_q ? '0 : rgb_x;
            end
        end
    end

    assign CE_PIX = ce;
    assign PH     = ph_q;
    assign PV     = pv_q;
    assign HBLK   = hblk_q;
    assign VBLK   = vblk_q;
    assign HSYNC  = hs_q;
    assign VSYNC  = vs_q;
    assign R      = rgb_q.r;
    assign G      = rgb_q.g;
    assign B      = rgb_q.b;

endmodule
